// File: rtl/packet_tx_sched.sv
// Packet transmit scheduler: snapshots a packet on frame_tick and streams it bytewise
// over a valid/ready handshake, then enforces an idle gap. Optional macro: PACKET_TX_SCHED_CHECKSUM_EN.
`timescale 1ns/1ps
module packet_tx_sched #(
    parameter int unsigned PKT_BYTES  = 22,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic [PKT_BYTES*8-1:0] packet,
    input  logic                   byte_ready,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    output logic                   busy,
    output logic                   frame_done,
    output logic [15:0]            frame_count,
    output logic [7:0]             drop_count
);

    localparam int unsigned PKT_W = PKT_BYTES * 8;
    localparam int unsigned IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef PACKET_TX_SCHED_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, CSUM = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
`endif

    state_t             r_state, w_state_nxt;
    logic [PKT_W-1:0]   r_snap, w_snap_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt, w_idx_inc;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic [7:0]         r_byte_data, w_byte_data_nxt;
    logic               r_byte_valid, w_byte_valid_nxt;
    logic               r_busy;
    logic [15:0]        r_frame_count, w_frame_count_nxt;
    logic [7:0]         r_drop_count, w_drop_count_nxt;
    logic               w_xfer;
    logic               w_frame_done;

    // Select one byte of the snapshot by index
    function automatic logic [7:0] pick_byte(input logic [PKT_W-1:0] snap,
                                             input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int unsigned i = 0; i < PKT_BYTES; i++) begin
            if (idx == IDX_W'(i)) b = snap[i*8 +: 8];
        end
        return b;
    endfunction

`ifdef PACKET_TX_SCHED_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [PKT_W-1:0] snap);
        logic [7:0] acc;
        acc = 8'h00;
        for (int unsigned i = 0; i < PKT_BYTES; i++) acc = acc ^ snap[i*8 +: 8];
        return acc;
    endfunction
`endif

    assign w_xfer    = r_byte_valid & byte_ready;
    assign w_idx_inc = IDX_W'(r_idx + 1'b1);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_snap_nxt        = r_snap;
        w_idx_nxt         = r_idx;
        w_gap_nxt         = r_gap;
        w_byte_data_nxt   = r_byte_data;
        w_byte_valid_nxt  = r_byte_valid;
        w_frame_count_nxt = r_frame_count;
        w_drop_count_nxt  = r_drop_count;
        w_frame_done      = 1'b0;

        if (frame_tick && (r_state != IDLE) && (r_drop_count != 8'hFF))
            w_drop_count_nxt = r_drop_count + 8'd1;

        case (r_state)
            IDLE: begin
                if (frame_tick) begin
                    w_snap_nxt       = packet;
                    w_idx_nxt        = '0;
                    w_state_nxt      = SEND;
                    w_byte_valid_nxt = 1'b1;
                    w_byte_data_nxt  = packet[7:0];
                end
            end
            SEND: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
`ifdef PACKET_TX_SCHED_CHECKSUM_EN
                        w_state_nxt     = CSUM;
                        w_byte_data_nxt = xor_bytes(r_snap);
`else
                        w_frame_done      = 1'b1;
                        w_frame_count_nxt = r_frame_count + 16'd1;
                        w_byte_valid_nxt  = 1'b0;
                        w_byte_data_nxt   = 8'h00;
                        w_gap_nxt         = '0;
                        w_state_nxt       = (GAP_CYCLES == 0) ? IDLE : GAP;
`endif
                    end else begin
                        w_idx_nxt       = w_idx_inc;
                        w_byte_data_nxt = pick_byte(r_snap, w_idx_inc);
                    end
                end
            end
`ifdef PACKET_TX_SCHED_CHECKSUM_EN
            CSUM: begin
                if (w_xfer) begin
                    w_frame_done      = 1'b1;
                    w_frame_count_nxt = r_frame_count + 16'd1;
                    w_byte_valid_nxt  = 1'b0;
                    w_byte_data_nxt   = 8'h00;
                    w_gap_nxt         = '0;
                    w_state_nxt       = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
`endif
            GAP: begin
                if (r_gap == GAP_LAST) w_state_nxt = IDLE;
                else                   w_gap_nxt   = GAP_W'(r_gap + 1'b1);
            end
            default: begin
                w_state_nxt      = IDLE;
                w_byte_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_snap        <= '0;
            r_idx         <= '0;
            r_gap         <= '0;
            r_byte_data   <= 8'h00;
            r_byte_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= 16'h0000;
            r_drop_count  <= 8'h00;
        end else begin
            r_state       <= w_state_nxt;
            r_snap        <= w_snap_nxt;
            r_idx         <= w_idx_nxt;
            r_gap         <= w_gap_nxt;
            r_byte_data   <= w_byte_data_nxt;
            r_byte_valid  <= w_byte_valid_nxt;
            r_busy        <= (w_state_nxt != IDLE);
            r_frame_count <= w_frame_count_nxt;
            r_drop_count  <= w_drop_count_nxt;
        end
    end

    // frame_done must coincide with the final handshake, so it is decoded from the live transfer
    assign frame_done  = w_frame_done;
    assign byte_data   = r_byte_data;
    assign byte_valid  = r_byte_valid;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;

endmodule

// File: doc/packet_tx_sched.md
PACKET_TX_SCHED -- requirements
Module: packet_tx_sched

Interface
REQ-001 SHALL have parameter PKT_BYTES, default 22, number of payload bytes taken from packet (176 bits / 8).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, minimum idle clocks between frames (0 allowed).
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  sole clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have these other ports:
- frame_tick  input  1  one-cycle request to transmit the current packet.
- packet  input  176  assembled packet; byte 0 = bits [7:0] (0xAA), byte 1 = 0x55.
- byte_ready  input  1  downstream (UART) can accept a byte.
- byte_data  output  8  byte offered downstream.
- byte_valid  output  1  byte_data is valid.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse on the last byte transfer of a frame.
- frame_count  output  16  frames completed, wraps at 0xFFFF -> 0.
- drop_count  output  8  frame_tick requests ignored, saturates at 0xFF.

Function
REQ-005 SHALL implement FSM states IDLE, SEND, GAP, plus CSUM when CHECKSUM_EN is defined.
REQ-006 In IDLE with frame_tick=1, SHALL capture packet into a 176-bit snapshot, clear the byte index and enter SEND on the next edge.
REQ-007 SHALL assert byte_valid on the first cycle after the accepted frame_tick (latency 1), with byte_data = snapshot byte 0.
REQ-008 A transfer SHALL occur on a cycle with byte_valid=1 and byte_ready=1; byte_data SHALL remain stable while byte_valid=1 and byte_ready=0.
REQ-009 On each transfer in SEND, SHALL advance the index by 1; bytes SHALL leave in order 0..PKT_BYTES-1, LSB byte first.
REQ-010 On the transfer of byte PKT_BYTES-1, SHALL pulse frame_done, increment frame_count and leave SEND (to CSUM if enabled, else GAP).
REQ-011 In GAP, byte_valid SHALL be 0 for exactly GAP_CYCLES clocks before returning to IDLE; with GAP_CYCLES=0 SHALL go directly to IDLE.
REQ-012 A frame_tick arriving in any state other than IDLE SHALL be dropped and SHALL increment drop_count (saturating); the snapshot SHALL be unchanged.
REQ-013 Changes on packet during SEND/GAP SHALL NOT affect transmitted bytes.
REQ-014 byte_ready while byte_valid=0 SHALL have no effect.
REQ-015 frame_done and frame_count SHALL update in the same cycle as the final byte transfer (the checksum byte when enabled).

Reset
REQ-016 rst_n=0 SHALL immediately force state IDLE, byte_valid=0, byte_data=0, busy=0, frame_done=0, frame_count=0, drop_count=0, snapshot=0, index=0.
REQ-017 Reset asserted mid-frame SHALL abandon the frame without counting it; after release, SHALL accept the next frame_tick normally.

Configuration
REQ-018 Macro PACKET_TX_SCHED_CHECKSUM_EN SHALL, when defined, append byte PKT_BYTES: XOR of all PKT_BYTES snapshot bytes, sent in state CSUM with the same handshake; frame_done then fires on the checksum transfer.
REQ-019 Without PACKET_TX_SCHED_CHECKSUM_EN, exactly PKT_BYTES bytes SHALL be sent per frame and no CSUM state or checksum logic SHALL exist.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- byte_ready=1 constantly, packet = 0x55AA at [15:0], 0x11 elsewhere, one tick -> bytes AA,55,11x20 on 22 consecutive cycles starting 1 cycle after tick; frame_done on the 22nd; frame_count=1.
- byte_ready toggled 1,0,1,0 -> each byte held stable while ready=0; 22 bytes, order unchanged; total SEND time 43 cycles.
- second tick 5 cycles after the first, then a third during GAP -> drop_count=2, only one frame sent; a tick 17+ cycles after frame_done is accepted.
- packet changed to all-0xFF mid-frame -> remaining bytes still from the snapshot.
- rst_n low at byte 10 -> byte_valid=0 at once, frame_count=0; next tick sends a full frame from byte 0.
- with PACKET_TX_SCHED_CHECKSUM_EN, packet AA,55,then 20 x 0x00 -> 23rd byte = 0xFF; frame_done on byte 23.
